// File: rtl/pipe_sched_if.sv
// Decode/execute/divider/bus signal bundle between the core and the hold/flush scheduler.
// The master side drives the request inputs; the slave side (the scheduler) returns hold/jump/status.
interface pipe_sched_if;
    logic [4:0]  id_reg1_raddr_i;
    logic [4:0]  id_reg2_raddr_i;
    logic [4:0]  id_reg_waddr_i;
    logic        id_reg_we_i;
    logic        id_is_div_i;
    logic        ex_is_load_i;
    logic [4:0]  ex_reg_waddr_i;
    logic        ex_reg_we_i;
    logic        div_start_i;
    logic [4:0]  div_waddr_i;
    logic        div_done_i;
    logic        jump_flag_i;
    logic [31:0] jump_addr_i;
    logic        rib_hold_i;
    logic        clint_hold_i;
    logic [2:0]  hold_flag_o;
    logic        jump_flag_o;
    logic [31:0] jump_addr_o;
    logic        div_busy_o;
    logic        div_timeout_o;
    logic [31:0] stall_cnt_o;

    modport master (
        output id_reg1_raddr_i, id_reg2_raddr_i, id_reg_waddr_i, id_reg_we_i, id_is_div_i,
        output ex_is_load_i, ex_reg_waddr_i, ex_reg_we_i,
        output div_start_i, div_waddr_i, div_done_i,
        output jump_flag_i, jump_addr_i, rib_hold_i, clint_hold_i,
        input  hold_flag_o, jump_flag_o, jump_addr_o, div_busy_o, div_timeout_o, stall_cnt_o
    );

    modport slave (
        input  id_reg1_raddr_i, id_reg2_raddr_i, id_reg_waddr_i, id_reg_we_i, id_is_div_i,
        input  ex_is_load_i, ex_reg_waddr_i, ex_reg_we_i,
        input  div_start_i, div_waddr_i, div_done_i,
        input  jump_flag_i, jump_addr_i, rib_hold_i, clint_hold_i,
        output hold_flag_o, jump_flag_o, jump_addr_o, div_busy_o, div_timeout_o, stall_cnt_o
    );
endinterface

// File: rtl/pipe_sched.sv
// Central hold/flush scheduler: priority-resolves bus/interrupt holds, jump flushes,
// load-use hazards and a one-entry divider scoreboard into a single hold level.
module pipe_sched #(
    parameter int unsigned DIV_TIMEOUT  = 64,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    pipe_sched_if.slave bus
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } div_state_e;

    localparam logic [7:0] TO_LAST = 8'(DIV_TIMEOUT - 1);
    localparam logic [1:0] FL_LOAD = 2'(FLUSH_CYCLES - 1);

    div_state_e  state_q, state_d;
    logic [4:0]  sb_waddr_q, sb_waddr_d;
    logic [7:0]  to_cnt_q, to_cnt_d;
    logic        timeout_q, timeout_d;
    logic [1:0]  flush_q, flush_d;
    logic [31:0] stall_q, stall_d;

    logic        load_use_s;
    logic        div_haz_s;
    logic        sb_match_s;
    logic [2:0]  hold_s;

    assign load_use_s = bus.ex_is_load_i && bus.ex_reg_we_i && (bus.ex_reg_waddr_i != 5'd0) &&
                        ((bus.ex_reg_waddr_i == bus.id_reg1_raddr_i) ||
                         (bus.ex_reg_waddr_i == bus.id_reg2_raddr_i));

    assign sb_match_s = (sb_waddr_q != 5'd0) &&
                        ((sb_waddr_q == bus.id_reg1_raddr_i) ||
                         (sb_waddr_q == bus.id_reg2_raddr_i) ||
                         (bus.id_reg_we_i && (sb_waddr_q == bus.id_reg_waddr_i)));

    // A divide finishing this cycle forwards its result, so it no longer blocks decode.
    assign div_haz_s = (state_q == S_BUSY) && !bus.div_done_i && (bus.id_is_div_i || sb_match_s);

    always_comb begin
        hold_s = 3'd0;
        if (rst) begin
            hold_s = 3'd0;
        end else if (bus.jump_flag_i || (flush_q != 2'd0)) begin
            hold_s = 3'd3;
        end else if (bus.rib_hold_i) begin
            hold_s = 3'd1;
        end else if (bus.clint_hold_i || div_haz_s || load_use_s) begin
            hold_s = 3'd3;
        end else begin
            hold_s = 3'd0;
        end
    end

    always_comb begin
        flush_d = flush_q;
        stall_d = stall_q;
        if (bus.jump_flag_i) begin
            flush_d = FL_LOAD;
        end else if (flush_q != 2'd0) begin
            flush_d = flush_q - 2'd1;
        end else begin
            flush_d = 2'd0;
        end
        if (hold_s != 3'd0) begin
            stall_d = stall_q + 32'd1;
        end else begin
            stall_d = stall_q;
        end
    end

    // Divider scoreboard: jumps never touch it because the divide is older than the jump.
    always_comb begin
        state_d    = state_q;
        sb_waddr_d = sb_waddr_q;
        to_cnt_d   = to_cnt_q;
        timeout_d  = timeout_q;
        case (state_q)
            S_IDLE: begin
                if (bus.div_start_i) begin
                    state_d    = S_BUSY;
                    sb_waddr_d = bus.div_waddr_i;
                    to_cnt_d   = 8'd0;
                end else begin
                    state_d    = S_IDLE;
                end
            end
            S_BUSY: begin
                if (bus.div_done_i && bus.div_start_i) begin
                    state_d    = S_BUSY;
                    sb_waddr_d = bus.div_waddr_i;
                    to_cnt_d   = 8'd0;
                end else if (bus.div_done_i) begin
                    state_d    = S_IDLE;
                end else if (to_cnt_q == TO_LAST) begin
                    state_d    = S_IDLE;
                    timeout_d  = 1'b1;
                end else begin
                    to_cnt_d   = to_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            sb_waddr_q <= 5'd0;
            to_cnt_q   <= 8'd0;
            timeout_q  <= 1'b0;
            flush_q    <= 2'd0;
            stall_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            sb_waddr_q <= sb_waddr_d;
            to_cnt_q   <= to_cnt_d;
            timeout_q  <= timeout_d;
            flush_q    <= flush_d;
            stall_q    <= stall_d;
        end
    end

    assign bus.hold_flag_o   = hold_s;
    assign bus.jump_flag_o   = rst ? 1'b0  : bus.jump_flag_i;
    assign bus.jump_addr_o   = rst ? 32'd0 : bus.jump_addr_i;
    assign bus.div_busy_o    = (state_q == S_BUSY);
    assign bus.div_timeout_o = timeout_q;
    assign bus.stall_cnt_o   = stall_q;

endmodule

// File: tb/tb_pipe_sched.sv
// Self-checking bench for pipe_sched: hazard vector table plus scoreboard-checked sequences
// on a FLUSH_CYCLES=2 instance, and a DIV_TIMEOUT=4 / FLUSH_CYCLES=1 instance for timeout.
module tb_pipe_sched;

    logic clk = 1'b0;
    logic rst;
    logic rst_b;

    always #5 clk = ~clk;

    pipe_sched_if bus_a();
    pipe_sched_if bus_b();

    pipe_sched #(.DIV_TIMEOUT(64), .FLUSH_CYCLES(2)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    pipe_sched #(.DIV_TIMEOUT(4), .FLUSH_CYCLES(1)) u_dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b)
    );

    typedef struct {
        string       name;
        logic [2:0]  hold;
        logic        jf;
        logic [31:0] ja;
        logic        busy;
        logic        to;
        logic [31:0] stall;
    } exp_t;

    typedef struct {
        string      name;
        logic [4:0] r1;
        logic [4:0] r2;
        logic [4:0] rd;
        logic       we;
        logic       isdiv;
        logic       ld;
        logic [4:0] ewa;
        logic       ewe;
        logic       rib;
        logic       clint;
        logic [2:0] hold;
    } vec_t;

    exp_t        sb_q[$];
    vec_t        vt[11];
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] model_stall = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clr_a();
        bus_a.id_reg1_raddr_i = 5'd0;
        bus_a.id_reg2_raddr_i = 5'd0;
        bus_a.id_reg_waddr_i  = 5'd0;
        bus_a.id_reg_we_i     = 1'b0;
        bus_a.id_is_div_i     = 1'b0;
        bus_a.ex_is_load_i    = 1'b0;
        bus_a.ex_reg_waddr_i  = 5'd0;
        bus_a.ex_reg_we_i     = 1'b0;
        bus_a.div_start_i     = 1'b0;
        bus_a.div_waddr_i     = 5'd0;
        bus_a.div_done_i      = 1'b0;
        bus_a.jump_flag_i     = 1'b0;
        bus_a.jump_addr_i     = 32'd0;
        bus_a.rib_hold_i      = 1'b0;
        bus_a.clint_hold_i    = 1'b0;
    endtask

    task automatic clr_b();
        bus_b.id_reg1_raddr_i = 5'd0;
        bus_b.id_reg2_raddr_i = 5'd0;
        bus_b.id_reg_waddr_i  = 5'd0;
        bus_b.id_reg_we_i     = 1'b0;
        bus_b.id_is_div_i     = 1'b0;
        bus_b.ex_is_load_i    = 1'b0;
        bus_b.ex_reg_waddr_i  = 5'd0;
        bus_b.ex_reg_we_i     = 1'b0;
        bus_b.div_start_i     = 1'b0;
        bus_b.div_waddr_i     = 5'd0;
        bus_b.div_done_i      = 1'b0;
        bus_b.jump_flag_i     = 1'b0;
        bus_b.jump_addr_i     = 32'd0;
        bus_b.rib_hold_i      = 1'b0;
        bus_b.clint_hold_i    = 1'b0;
    endtask

    // One cycle on instance A: push expectation, compare at negedge, advance the stall model at the edge.
    task automatic cycle_a(input string name, input logic [2:0] hold, input logic busy, input logic to);
        exp_t e;
        exp_t g;
        e.name  = name;
        e.hold  = hold;
        e.jf    = rst ? 1'b0 : bus_a.jump_flag_i;
        e.ja    = rst ? 32'd0 : bus_a.jump_addr_i;
        e.busy  = busy;
        e.to    = to;
        e.stall = model_stall;
        sb_q.push_back(e);
        @(negedge clk);
        if (sb_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, got nothing, expected an entry", name);
        end else begin
            g = sb_q.pop_front();
            chk({g.name, ".hold"},  {29'd0, bus_a.hold_flag_o}, {29'd0, g.hold});
            chk({g.name, ".jf"},    {31'd0, bus_a.jump_flag_o}, {31'd0, g.jf});
            chk({g.name, ".ja"},    bus_a.jump_addr_o, g.ja);
            chk({g.name, ".busy"},  {31'd0, bus_a.div_busy_o}, {31'd0, g.busy});
            chk({g.name, ".to"},    {31'd0, bus_a.div_timeout_o}, {31'd0, g.to});
            chk({g.name, ".stall"}, bus_a.stall_cnt_o, g.stall);
        end
        @(posedge clk);
        if (rst) begin
            model_stall = 32'd0;
        end else if (hold != 3'd0) begin
            model_stall = model_stall + 32'd1;
        end
        #1;
    endtask

    initial begin
        //              name       r1     r2     rd     we    div   ld    ewa    ewe   rib   clint hold
        vt[0]  = '{"lu_rs2",     5'd0,  5'd5,  5'd0,  1'b0, 1'b0, 1'b1, 5'd5,  1'b1, 1'b0, 1'b0, 3'd3};
        vt[1]  = '{"lu_x0",      5'd0,  5'd5,  5'd0,  1'b0, 1'b0, 1'b1, 5'd0,  1'b1, 1'b0, 1'b0, 3'd0};
        vt[2]  = '{"lu_rs1",     5'd9,  5'd2,  5'd0,  1'b0, 1'b0, 1'b1, 5'd9,  1'b1, 1'b0, 1'b0, 3'd3};
        vt[3]  = '{"nonload",    5'd9,  5'd2,  5'd0,  1'b0, 1'b0, 1'b0, 5'd9,  1'b1, 1'b0, 1'b0, 3'd0};
        vt[4]  = '{"load_nowe",  5'd9,  5'd2,  5'd0,  1'b0, 1'b0, 1'b1, 5'd9,  1'b0, 1'b0, 1'b0, 3'd0};
        vt[5]  = '{"lu_nomatch", 5'd8,  5'd2,  5'd0,  1'b0, 1'b0, 1'b1, 5'd9,  1'b1, 1'b0, 1'b0, 3'd0};
        vt[6]  = '{"rib",        5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 3'd1};
        vt[7]  = '{"rib_lu",     5'd0,  5'd5,  5'd0,  1'b0, 1'b0, 1'b1, 5'd5,  1'b1, 1'b1, 1'b0, 3'd1};
        vt[8]  = '{"clint",      5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 3'd3};
        vt[9]  = '{"clint_rib",  5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b1, 3'd1};
        vt[10] = '{"div_idle",   5'd7,  5'd7,  5'd7,  1'b1, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 3'd0};

        rst   = 1'b1;
        rst_b = 1'b1;
        clr_a();
        clr_b();
        @(posedge clk);
        #1;

        // Reset: outputs forced low even with a jump request present.
        bus_a.jump_flag_i = 1'b1;
        bus_a.jump_addr_i = 32'hDEAD_BEEF;
        cycle_a("reset", 3'd0, 1'b0, 1'b0);
        rst = 1'b0;
        clr_a();

        for (int i = 0; i < 11; i++) begin
            bus_a.id_reg1_raddr_i = vt[i].r1;
            bus_a.id_reg2_raddr_i = vt[i].r2;
            bus_a.id_reg_waddr_i  = vt[i].rd;
            bus_a.id_reg_we_i     = vt[i].we;
            bus_a.id_is_div_i     = vt[i].isdiv;
            bus_a.ex_is_load_i    = vt[i].ld;
            bus_a.ex_reg_waddr_i  = vt[i].ewa;
            bus_a.ex_reg_we_i     = vt[i].ewe;
            bus_a.rib_hold_i      = vt[i].rib;
            bus_a.clint_hold_i    = vt[i].clint;
            cycle_a(vt[i].name, vt[i].hold, 1'b0, 1'b0);
        end
        clr_a();

        // Divider RAW: rs1 waits on the divide for 10 cycles, released in the done cycle.
        bus_a.div_start_i = 1'b1;
        bus_a.div_waddr_i = 5'd7;
        cycle_a("raw_start", 3'd0, 1'b0, 1'b0);
        bus_a.div_start_i     = 1'b0;
        bus_a.id_reg1_raddr_i = 5'd7;
        for (int i = 0; i < 10; i++) begin
            cycle_a("raw_wait", 3'd3, 1'b1, 1'b0);
        end
        bus_a.div_done_i = 1'b1;
        cycle_a("raw_done", 3'd0, 1'b1, 1'b0);
        clr_a();
        cycle_a("raw_idle", 3'd0, 1'b0, 1'b0);

        // Divider independent, WAW and back-to-back restart.
        bus_a.div_start_i = 1'b1;
        bus_a.div_waddr_i = 5'd7;
        cycle_a("ind_start", 3'd0, 1'b0, 1'b0);
        clr_a();
        bus_a.id_reg1_raddr_i = 5'd3;
        bus_a.id_reg2_raddr_i = 5'd4;
        bus_a.id_reg_waddr_i  = 5'd9;
        bus_a.id_reg_we_i     = 1'b1;
        cycle_a("ind_free", 3'd0, 1'b1, 1'b0);
        bus_a.id_is_div_i = 1'b1;
        cycle_a("ind_div", 3'd3, 1'b1, 1'b0);
        bus_a.id_is_div_i    = 1'b0;
        bus_a.id_reg_waddr_i = 5'd7;
        cycle_a("ind_waw", 3'd3, 1'b1, 1'b0);
        bus_a.id_reg_we_i = 1'b0;
        cycle_a("ind_rd_nowe", 3'd0, 1'b1, 1'b0);
        clr_a();
        bus_a.div_done_i      = 1'b1;
        bus_a.div_start_i     = 1'b1;
        bus_a.div_waddr_i     = 5'd12;
        bus_a.id_reg1_raddr_i = 5'd12;
        cycle_a("b2b_restart", 3'd0, 1'b1, 1'b0);
        clr_a();
        bus_a.id_reg1_raddr_i = 5'd12;
        cycle_a("b2b_new", 3'd3, 1'b1, 1'b0);
        bus_a.id_reg1_raddr_i = 5'd7;
        cycle_a("b2b_old", 3'd0, 1'b1, 1'b0);
        bus_a.div_done_i = 1'b1;
        cycle_a("b2b_done", 3'd0, 1'b1, 1'b0);
        clr_a();
        cycle_a("b2b_idle", 3'd0, 1'b0, 1'b0);

        // Jump flush of 2 cycles overrides rib hold; then re-jump while flushing.
        bus_a.jump_flag_i = 1'b1;
        bus_a.jump_addr_i = 32'h0000_0100;
        bus_a.rib_hold_i  = 1'b1;
        cycle_a("jmp", 3'd3, 1'b0, 1'b0);
        bus_a.jump_flag_i = 1'b0;
        bus_a.jump_addr_i = 32'd0;
        cycle_a("jmp_flush", 3'd3, 1'b0, 1'b0);
        cycle_a("jmp_rib", 3'd1, 1'b0, 1'b0);
        clr_a();
        bus_a.jump_flag_i = 1'b1;
        bus_a.jump_addr_i = 32'h0000_0200;
        cycle_a("rejmp1", 3'd3, 1'b0, 1'b0);
        bus_a.jump_addr_i = 32'h0000_0300;
        cycle_a("rejmp2", 3'd3, 1'b0, 1'b0);
        clr_a();
        cycle_a("rejmp_flush", 3'd3, 1'b0, 1'b0);
        cycle_a("rejmp_end", 3'd0, 1'b0, 1'b0);

        // Jump does not clear the scoreboard.
        bus_a.div_start_i = 1'b1;
        bus_a.div_waddr_i = 5'd7;
        cycle_a("jd_start", 3'd0, 1'b0, 1'b0);
        clr_a();
        bus_a.jump_flag_i = 1'b1;
        bus_a.jump_addr_i = 32'h0000_0400;
        cycle_a("jd_jump", 3'd3, 1'b1, 1'b0);
        clr_a();
        cycle_a("jd_flush", 3'd3, 1'b1, 1'b0);
        bus_a.id_reg2_raddr_i = 5'd7;
        cycle_a("jd_raw", 3'd3, 1'b1, 1'b0);

        // Priority, then reset mid-BUSY.
        bus_a.id_reg2_raddr_i = 5'd0;
        bus_a.rib_hold_i      = 1'b1;
        bus_a.ex_is_load_i    = 1'b1;
        bus_a.ex_reg_we_i     = 1'b1;
        bus_a.ex_reg_waddr_i  = 5'd5;
        bus_a.id_reg1_raddr_i = 5'd5;
        cycle_a("prio_rib", 3'd1, 1'b1, 1'b0);
        clr_a();
        rst = 1'b1;
        bus_a.jump_flag_i     = 1'b1;
        bus_a.jump_addr_i     = 32'h0000_0500;
        bus_a.id_reg1_raddr_i = 5'd7;
        cycle_a("rst_edge", 3'd0, 1'b1, 1'b0);
        cycle_a("rst_held", 3'd0, 1'b0, 1'b0);
        rst = 1'b0;
        clr_a();
        bus_a.div_done_i      = 1'b1;
        bus_a.id_reg1_raddr_i = 5'd7;
        cycle_a("post_rst_done", 3'd0, 1'b0, 1'b0);
        clr_a();
        cycle_a("post_rst_idle", 3'd0, 1'b0, 1'b0);

        // Instance B: DIV_TIMEOUT=4, FLUSH_CYCLES=1.
        rst_b = 1'b0;
        bus_b.div_start_i = 1'b1;
        bus_b.div_waddr_i = 5'd3;
        @(posedge clk);
        #1;
        clr_b();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("to_busy", {31'd0, bus_b.div_busy_o}, 32'd1);
            chk("to_pending", {31'd0, bus_b.div_timeout_o}, 32'd0);
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("to_released", {31'd0, bus_b.div_busy_o}, 32'd0);
            chk("to_sticky", {31'd0, bus_b.div_timeout_o}, 32'd1);
            @(posedge clk);
            #1;
        end
        bus_b.jump_flag_i = 1'b1;
        bus_b.jump_addr_i = 32'h0000_0040;
        @(negedge clk);
        chk("f1_jump_hold", {29'd0, bus_b.hold_flag_o}, 32'd3);
        chk("f1_jump_addr", bus_b.jump_addr_o, 32'h0000_0040);
        @(posedge clk);
        #1;
        clr_b();
        @(negedge clk);
        chk("f1_no_flush", {29'd0, bus_b.hold_flag_o}, 32'd0);
        chk("f1_stall", bus_b.stall_cnt_o, 32'd1);
        chk("to_sticky_jump", {31'd0, bus_b.div_timeout_o}, 32'd1);
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("to_rst_clear", {31'd0, bus_b.div_timeout_o}, 32'd0);
        chk("to_rst_stall", bus_b.stall_cnt_o, 32'd0);
        rst_b = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_sched.md
Name: pipe_sched

Overview:
- Central hold/flush scheduler for the 3-stage core (pc / if_id / id_ex) and the decode stage.
- Combines bus and interrupt hold requests, execute-stage jump flushes, load-use hazards and a one-entry scoreboard for the multi-cycle divider.
- Produces one priority-resolved hold_flag_o, forwards the jump request, and keeps a stall-cycle counter.
- Sits beside the decoder, between ex, div, rib and clint.

Parameters:
- DIV_TIMEOUT, 64, cycles the divider may stay busy before it is forcibly released; legal range 2..255.
- FLUSH_CYCLES, 1, hold-id cycles inserted after a taken jump; legal range 1..3.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- id_reg1_raddr_i  in  5  rs1 address being decoded
- id_reg2_raddr_i  in  5  rs2 address being decoded
- id_reg_waddr_i  in  5  rd address being decoded
- id_reg_we_i  in  1  decoded instruction writes rd
- id_is_div_i  in  1  decoded instruction is DIV/DIVU/REM/REMU
- ex_is_load_i  in  1  instruction in ex is a load
- ex_reg_waddr_i  in  5  rd of instruction in ex
- ex_reg_we_i  in  1  ex instruction writes rd
- div_start_i  in  1  divider accepted an operation this cycle
- div_waddr_i  in  5  rd of the accepted divide
- div_done_i  in  1  divider result written back this cycle
- jump_flag_i  in  1  ex requests a jump
- jump_addr_i  in  32  jump target
- rib_hold_i  in  1  bus arbiter hold request
- clint_hold_i  in  1  interrupt controller hold request
- hold_flag_o  out  3  0 none, 1 hold pc, 2 hold pc+if_id, 3 hold pc+if_id and bubble id_ex
- jump_flag_o  out  1  jump to pc register
- jump_addr_o  out  32  jump target to pc register
- div_busy_o  out  1  scoreboard entry valid
- div_timeout_o  out  1  sticky divider-timeout error
- stall_cnt_o  out  32  cycles with hold_flag_o != 0

Behaviour:
- Reset (rst=1 at a clk edge): FSM to IDLE, div_busy_o=0, div_timeout_o=0, stall_cnt_o=0, flush counter=0, timeout counter=0, scoreboard waddr=0.
  - hold_flag_o, jump_flag_o and jump_addr_o are combinational and read 0 while rst=1.
- Pass-through: jump_flag_o = jump_flag_i and jump_addr_o = jump_addr_i in the same cycle, not gated by any hold.
- Hazard terms, all combinational in the same cycle:
  - load_use = ex_is_load_i & ex_reg_we_i & ex_reg_waddr_i != 0 & (ex_reg_waddr_i == id_reg1_raddr_i | ex_reg_waddr_i == id_reg2_raddr_i).
  - div_haz = div_busy_o & !div_done_i & (id_is_div_i | (sb_waddr != 0 & (sb_waddr == id_reg1_raddr_i | sb_waddr == id_reg2_raddr_i | (id_reg_we_i & sb_waddr == id_reg_waddr_i)))).
- hold_flag_o priority, first match wins:
  - jump_flag_i or flush counter != 0 -> 3.
  - rib_hold_i -> 1.
  - clint_hold_i -> 3.
  - div_haz -> 3.
  - load_use -> 3.
  - otherwise 0.
- Flush counter:
  - Loaded with FLUSH_CYCLES-1 on any cycle with jump_flag_i=1, including while already nonzero.
  - Otherwise decrements to 0.
  - With FLUSH_CYCLES=1 a jump holds exactly its own cycle.
- Divider FSM, states IDLE and BUSY:
  - IDLE -> BUSY on div_start_i; latches sb_waddr=div_waddr_i and clears the timeout counter.
  - BUSY -> IDLE on div_done_i.
  - BUSY with div_done_i and div_start_i in the same cycle: stays BUSY, latches the new waddr, clears the counter.
  - BUSY otherwise: counter increments.
  - BUSY when the counter reaches DIV_TIMEOUT-1 with no div_done_i: -> IDLE and div_timeout_o set; it stays 1 until rst.
  - div_start_i while BUSY without div_done_i is illegal; it is ignored and the state is unchanged.
  - Jumps and flushes never clear the scoreboard, because the divide is older than the jump.
- div_busy_o = (state == BUSY), registered.
- stall_cnt_o increments by 1 at each clk edge where hold_flag_o != 0 and rst=0; it wraps from 0xFFFFFFFF to 0.
- rst asserted mid-divide aborts tracking immediately; a div_done_i arriving after reset is ignored in IDLE.

Test Plan:
- Load-use: ex_is_load_i=1, ex_reg_waddr_i=5, ex_reg_we_i=1, id_reg2_raddr_i=5 -> hold_flag_o=3 in the same cycle. Repeat with ex_reg_waddr_i=0 -> hold_flag_o=0.
- Divider RAW: div_start_i with waddr=7, then id_reg1_raddr_i=7 for 10 cycles, then div_done_i.
  - hold_flag_o=3 for cycles 1..10; 0 in the div_done_i cycle; div_busy_o falls on the next edge.
  - stall_cnt_o=10.
- Divider independent: while BUSY with waddr=7, decode rs1=3, rs2=4, rd=9 (not a div) -> hold_flag_o=0. Decode id_is_div_i=1 -> 3.
- Jump flush with FLUSH_CYCLES=2: jump_flag_i pulse, jump_addr_i=0x0000_0100.
  - jump_flag_o=1 and jump_addr_o=0x100 in the same cycle.
  - hold_flag_o=3 for 2 cycles, even while rib_hold_i=1.
- Timeout with DIV_TIMEOUT=4: div_start_i and no div_done_i -> div_busy_o high for 4 cycles, then div_timeout_o=1 and stays 1; rst clears it.
- Priority and reset: rib_hold_i=1 together with load_use -> hold_flag_o=1. Then rst=1 mid-BUSY -> next edge div_busy_o=0, stall_cnt_o=0; hold_flag_o=0 while rst=1.
